activation_scheduler: RTL and testbench
=======================================

ACTIVATION_SCHEDULER -- requirements
Module: activation_scheduler

Interface
REQ-001 Parameter NUM_CH, default 32: number of activation elements sequenced.
REQ-002 Parameter TIMER_WIDTH, default 5: width of spike counts and timestep counter.
REQ-003 Parameter CH_W, default 5: width of readout channel index, equal to clog2(NUM_CH).
REQ-004 One clock, clk; reset rst is synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- num_steps  in  TIMER_WIDTH  timesteps per run; latched on accepted start.
- psum_req  out  1  request one timestep of membrane potentials from the array.
- psum_ack  in  1  array reports potentials valid.
- act_en  out  1  one-cycle strobe; activation elements evaluate.
- act_clr  out  1  one-cycle strobe; clear element spike counters.
- spike_counts  in  NUM_CH*TIMER_WIDTH  flattened accumulated counts; channel i at bits [i*TIMER_WIDTH +: TIMER_WIDTH].
- rd_valid  out  1  readout word valid.
- rd_ready  in  1  readout consumer ready.
- rd_ch  out  CH_W  channel of the current readout word.
- rd_data  out  TIMER_WIDTH  spike count of channel rd_ch.
- step_idx  out  TIMER_WIDTH  current timestep, 0-based.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run completion.

Function
REQ-006 The FSM SHALL have states IDLE, CLEAR, REQ, WAIT, FIRE, READ, DONE.
REQ-007 IDLE->CLEAR on start=1 when num_steps!=0; start with num_steps=0 SHALL be ignored, and the FSM stays in IDLE.
REQ-008 CLEAR SHALL last one cycle with act_clr=1, clear step_idx to 0, then go to REQ.
REQ-009 REQ SHALL assert psum_req and go to WAIT the next cycle.
REQ-010 In WAIT, psum_req SHALL stay high until psum_ack=1.
REQ-011 On the cycle psum_ack=1, psum_req SHALL drop and the FSM SHALL go to FIRE.
REQ-012 psum_ack outside WAIT SHALL be ignored.
REQ-013 FIRE SHALL last one cycle with act_en=1.
REQ-014 From FIRE: if step_idx == latched num_steps-1, go to READ with rd_ch=0; otherwise increment step_idx and go to REQ.
REQ-015 In READ, rd_valid SHALL be 1, and rd_data SHALL be the combinational select of spike_counts for channel rd_ch.
REQ-016 A READ word transfers when rd_valid & rd_ready.
REQ-017 rd_ch SHALL advance only on a transfer.
REQ-018 The transfer of channel NUM_CH-1 SHALL move the FSM to DONE.
REQ-019 While rd_ready=0, rd_ch and rd_data SHALL hold stable.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 start while busy SHALL be ignored.
REQ-022 act_en, act_clr, psum_req and rd_valid SHALL be mutually exclusive in every cycle.
REQ-023 Minimum run latency SHALL be 3*num_steps + NUM_CH + 2 cycles, from the accepted start to the done pulse (psum_ack returned immediately, rd_ready held high).

Reset
REQ-024 rst SHALL return the FSM to IDLE in the next cycle from any state, including mid-run.
REQ-025 After reset, all outputs SHALL be 0 and step_idx and rd_ch SHALL be 0.
REQ-026 No done pulse SHALL be generated for an aborted run.

Configuration
REQ-027 With macro ACT_SCHED_STALL_CNT_EN defined, the block SHALL add output stall_cycles (16 bits).
REQ-028 stall_cycles SHALL clear in CLEAR, increment on every WAIT cycle with psum_ack=0, and saturate at 0xFFFF.
REQ-029 Without ACT_SCHED_STALL_CNT_EN, the stall_cycles port and its logic SHALL be absent.

Structure
REQ-030 Package act_sched_pkg SHALL hold the state enum type and the default values of NUM_CH and TIMER_WIDTH.
REQ-031 One sub-module, act_readout_mux, SHALL implement the NUM_CH-to-1 spike_counts select.

Verification
REQ-032 num_steps=3, psum_ack one cycle after each psum_req, rd_ready=1 -> act_clr once, act_en exactly 3 times with step_idx 0,1,2, 32 reads with rd_ch 0..31, done pulses at cycle 43 after start.
REQ-033 psum_ack delayed 5 cycles on step 1 -> psum_req held 5 extra cycles, no act_en until ack; with ACT_SCHED_STALL_CNT_EN, stall_cycles=5 at done.
REQ-034 rd_ready low for 4 cycles at rd_ch=7, spike_counts[7]=5'd19 -> rd_data=19 and rd_ch=7 stable for 4 cycles, then advance to 8.
REQ-035 start with num_steps=0 -> busy stays 0, no strobes; a second start while busy -> ignored, with run timing unchanged.
REQ-036 rst asserted in WAIT at step 2 -> next cycle IDLE, all outputs 0, no done; a fresh start then completes normally.

Source files
------------

// File: rtl/act_sched_pkg.sv
// Shared types and defaults for the activation scheduler.
// The state enum, the default array geometry and a saturating stall-counter helper.
package act_sched_pkg;

    localparam int NUM_CH_DEF      = 32;
    localparam int TIMER_WIDTH_DEF = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        FIRE  = 3'd4,
        READ  = 3'd5,
        DONE  = 3'd6
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/act_readout_mux.sv
// NUM_CH-to-1 select of the flattened spike-count bus.
// Purely combinational; channel i occupies bits [i*TIMER_WIDTH +: TIMER_WIDTH].
module act_readout_mux
    import act_sched_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int TIMER_WIDTH = TIMER_WIDTH_DEF,
    parameter int CH_W        = $clog2(NUM_CH)
) (
    input  logic [NUM_CH*TIMER_WIDTH-1:0] spike_counts,
    input  logic [CH_W-1:0]               sel,
    output logic [TIMER_WIDTH-1:0]        data
);

    // Loop form keeps out-of-range selects (non power-of-two NUM_CH) at zero.
    always_comb begin
        data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(sel) == i) begin
                data = spike_counts[i*TIMER_WIDTH +: TIMER_WIDTH];
            end
        end
    end

endmodule

// File: rtl/activation_scheduler.sv
// Sequences timestep requests, activation strobes and per-channel readout for an SNN array.
// Optional stall counter output enabled by defining ACT_SCHED_STALL_CNT_EN.
module activation_scheduler
    import act_sched_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int TIMER_WIDTH = TIMER_WIDTH_DEF,
    parameter int CH_W        = $clog2(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [TIMER_WIDTH-1:0]        num_steps,
    output logic                          psum_req,
    input  logic                          psum_ack,
    output logic                          act_en,
    output logic                          act_clr,
    input  logic [NUM_CH*TIMER_WIDTH-1:0] spike_counts,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [CH_W-1:0]               rd_ch,
    output logic [TIMER_WIDTH-1:0]        rd_data,
    output logic [TIMER_WIDTH-1:0]        step_idx,
    output logic                          busy,
    output logic                          done
`ifdef ACT_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cycles
`endif
);

    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] steps_q, steps_d;
    logic [TIMER_WIDTH-1:0] step_idx_q, step_idx_d;
    logic [CH_W-1:0]        rd_ch_q, rd_ch_d;
    logic                   psum_req_q, psum_req_d;
    logic                   act_en_q, act_en_d;
    logic                   act_clr_q, act_clr_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [TIMER_WIDTH-1:0] sel_data;

    always_comb begin
        state_d    = state_q;
        steps_d    = steps_q;
        step_idx_d = step_idx_q;
        rd_ch_d    = rd_ch_q;
        case (state_q)
            IDLE: begin
                if (start && (num_steps != '0)) begin
                    state_d = CLEAR;
                    steps_d = num_steps;
                end
            end
            CLEAR: begin
                step_idx_d = '0;
                state_d    = REQ;
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                if (psum_ack) state_d = FIRE;
            end
            FIRE: begin
                if (step_idx_q == steps_q - TIMER_WIDTH'(1)) begin
                    state_d = READ;
                    rd_ch_d = '0;
                end else begin
                    step_idx_d = step_idx_q + TIMER_WIDTH'(1);
                    state_d    = REQ;
                end
            end
            READ: begin
                if (rd_ready) begin
                    if (rd_ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = DONE;
                        rd_ch_d = '0;
                    end else begin
                        rd_ch_d = rd_ch_q + CH_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        psum_req_d = (state_d == REQ) || (state_d == WAIT);
        act_en_d   = (state_d == FIRE);
        act_clr_d  = (state_d == CLEAR);
        rd_valid_d = (state_d == READ);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            steps_q    <= '0;
            step_idx_q <= '0;
            rd_ch_q    <= '0;
            psum_req_q <= 1'b0;
            act_en_q   <= 1'b0;
            act_clr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            steps_q    <= steps_d;
            step_idx_q <= step_idx_d;
            rd_ch_q    <= rd_ch_d;
            psum_req_q <= psum_req_d;
            act_en_q   <= act_en_d;
            act_clr_q  <= act_clr_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    act_readout_mux #(
        .NUM_CH      (NUM_CH),
        .TIMER_WIDTH (TIMER_WIDTH),
        .CH_W        (CH_W)
    ) u_mux (
        .spike_counts (spike_counts),
        .sel          (rd_ch_q),
        .data         (sel_data)
    );

    assign psum_req = psum_req_q;
    assign act_en   = act_en_q;
    assign act_clr  = act_clr_q;
    assign rd_valid = rd_valid_q;
    assign rd_ch    = rd_ch_q;
    assign rd_data  = rd_valid_q ? sel_data : '0;
    assign step_idx = step_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef ACT_SCHED_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == CLEAR) begin
            stall_d = '0;
        end else if ((state_q == WAIT) && !psum_ack) begin
            stall_d = sat_inc16(stall_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_activation_scheduler.sv
// Randomized scoreboard bench for activation_scheduler: a run planner predicts every event
// and its cycle offset from start; a monitor pops and compares as the DUT presents them.
module tb_activation_scheduler;

    localparam int NC = 32;
    localparam int TW = 5;
    localparam int CW = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic [TW-1:0]     num_steps;
    logic              psum_req;
    logic              psum_ack;
    logic              act_en;
    logic              act_clr;
    logic [NC*TW-1:0]  spike_counts;
    logic              rd_valid;
    logic              rd_ready;
    logic [CW-1:0]     rd_ch;
    logic [TW-1:0]     rd_data;
    logic [TW-1:0]     step_idx;
    logic              busy;
    logic              done;
`ifdef ACT_SCHED_STALL_CNT_EN
    logic [15:0]       stall_cycles;
`endif

    activation_scheduler #(.NUM_CH(NC), .TIMER_WIDTH(TW), .CH_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_steps    (num_steps),
        .psum_req     (psum_req),
        .psum_ack     (psum_ack),
        .act_en       (act_en),
        .act_clr      (act_clr),
        .spike_counts (spike_counts),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_ch        (rd_ch),
        .rd_data      (rd_data),
        .step_idx     (step_idx),
        .busy         (busy),
        .done         (done)
`ifdef ACT_SCHED_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 clr, 1 act_en, 2 read transfer, 3 done
        int a;
        int b;
        int t;
    } ev_t;

    ev_t          exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           base = 0;
    bit           mon_on = 0;
    bit           stray_en = 0;
    int           dly[NC];
    int           stl[NC];
    logic [TW-1:0] cnts[NC];

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        spike_counts = '0;
        for (int i = 0; i < NC; i++) spike_counts[i*TW +: TW] = cnts[i];
    end

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Model of one run: events and their cycle offsets from the accepting edge.
    task automatic plan(input int n);
        int tr, f, r, x, stall;
        exp_q.push_back('{0, 0, 0, 1});
        tr = 2;
        stall = 0;
        for (int k = 0; k < n; k++) begin
            f = tr + dly[k] + 1;
            exp_q.push_back('{1, k, 0, f});
            stall += dly[k] - 1;
            tr = f + 1;
        end
        r = tr;
        for (int c = 0; c < NC; c++) begin
            x = r + stl[c];
            exp_q.push_back('{2, c, int'(cnts[c]), x});
            r = x + 1;
        end
        if (stall > 65535) stall = 65535;
`ifdef ACT_SCHED_STALL_CNT_EN
        exp_q.push_back('{3, 0, stall, r});
`else
        exp_q.push_back('{3, 0, 0, r});
`endif
    endtask

    task automatic pop_cmp(input string nm, input int kind, input int a, input int b, input bit do_pop);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({nm, "_unexpected"}, kind, -1);
        end else begin
            e = exp_q[0];
            check({nm, "_kind"}, kind, e.kind);
            check({nm, "_a"}, a, e.a);
            check({nm, "_b"}, b, e.b);
            if (do_pop) begin
                check({nm, "_cycle"}, cyc - base, e.t);
                void'(exp_q.pop_front());
            end
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_on && !rst) begin
                check("exclusive", int'(act_en) + int'(act_clr) + int'(psum_req) + int'(rd_valid) > 1, 0);
                if (act_clr) pop_cmp("clr", 0, 0, 0, 1'b1);
                if (act_en) pop_cmp("fire", 1, int'(step_idx), 0, 1'b1);
                if (rd_valid) pop_cmp("read", 2, int'(rd_ch), int'(rd_data), rd_ready);
`ifdef ACT_SCHED_STALL_CNT_EN
                if (done) pop_cmp("done", 3, 0, int'(stall_cycles), 1'b1);
`else
                if (done) pop_cmp("done", 3, 0, 0, 1'b1);
`endif
            end
        end
    end

    // Array model: acks after the planned delay, stray acks when no request is pending.
    initial begin
        int k, cnt;
        bit prev;
        k = 0; cnt = 0; prev = 0;
        psum_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (act_clr) k = 0;
            if (psum_req && !prev) begin
                cnt = dly[k < NC ? k : NC-1];
                k++;
                psum_ack = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                psum_ack = (cnt == 0);
            end else begin
                psum_ack = (!psum_req && stray_en) ? 1'($urandom % 2) : 1'b0;
            end
            prev = psum_req;
        end
    end

    // Readout consumer: holds rd_ready low for the planned stall on each channel.
    initial begin
        int ch, cnt;
        ch = 0; cnt = 0;
        rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_valid && ch < NC) begin
                if (cnt < stl[ch]) begin
                    rd_ready = 1'b0;
                    cnt++;
                end else begin
                    rd_ready = 1'b1;
                    cnt = 0;
                    ch++;
                end
            end else begin
                rd_ready = 1'($urandom % 2);
                ch = 0;
                cnt = 0;
            end
        end
    end

    task automatic set_default();
        for (int i = 0; i < NC; i++) begin
            dly[i]  = 1;
            stl[i]  = 0;
            cnts[i] = TW'($urandom);
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_psum_req"}, psum_req, 0);
        check({tag, "_act_en"}, act_en, 0);
        check({tag, "_act_clr"}, act_clr, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_step_idx"}, int'(step_idx), 0);
        check({tag, "_rd_ch"}, int'(rd_ch), 0);
        check({tag, "_rd_data"}, int'(rd_data), 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        check("run_complete_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input int n);
        @(negedge clk);
        base = cyc;
        plan(n);
        start = 1'b1;
        num_steps = TW'(n);
        @(negedge clk);
        start = 1'b0;
        num_steps = TW'($urandom);
    endtask

    task automatic run(input int n, input bit busy_start);
        issue(n);
        if (busy_start) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            num_steps = TW'(3);
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_steps = '0;
        set_default();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #3;
        chk_idle("reset");
        mon_on = 1'b1;

        // Nominal three-step run.
        set_default();
        run(3, 1'b0);

        // Delayed ack on step 1.
        set_default();
        dly[1] = 6;
        run(3, 1'b0);

        // Readout back-pressure at channel 7.
        set_default();
        cnts[7] = 5'd19;
        stl[7] = 4;
        run(2, 1'b0);

        // start with zero steps is ignored.
        @(negedge clk);
        start = 1'b1;
        num_steps = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #3;
            check("zero_steps_busy", busy, 0);
        end

        // start while busy is ignored.
        set_default();
        run(2, 1'b1);

        // Abort in WAIT of step 2, then a fresh run.
        set_default();
        dly[2] = 8;
        issue(4);
        for (int i = 0; i < 40 && (cyc - base) < 10; i++) @(negedge clk);
        check("abort_in_wait", psum_req, 1);
        check("abort_step", int'(step_idx), 2);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk_idle("abort");
        repeat (12) @(negedge clk);
        set_default();
        run(3, 1'b0);

        // Randomized runs with stray acks and random stalls.
        stray_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            set_default();
            for (int k = 0; k < NC; k++) dly[k] = $urandom_range(1, 4);
            for (int c = 0; c < NC; c++) stl[c] = $urandom_range(0, 2);
            run($urandom_range(1, 5), r[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
